// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multicycle MIPS control FSM: IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB,
//   plus an absorbing HALTED state. Owns the instruction register, waits on
//   ihit/dhit, runs a memory-wait watchdog and counts retired instructions.
//
// Parameters
//   MAX_WAIT  max consecutive no-hit cycles in FETCH/MEM before timeout (0 = off)
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   instr, ihit          instruction word and instruction memory hit
//   dhit, zero           data memory hit, ALU zero flag (rs - rt)
//   iREN, dREN, dWEN     memory requests
//   ir_q                 latched instruction register
//   pc_en, pc_src        PC load strobe / source (0 +4, 1 branch, 2 jump, 3 rs)
//   reg_wen, reg_dst     register write strobe / destination (0 rt, 1 rd, 2 $31)
//   alu_src, alu_op      ALU B select (1 = immediate), ALU operation
//   ext_op               1 = sign extend immediate
//   mem_to_reg, lui      write-back source selects
//   halt, mem_timeout    halted, sticky watchdog flag
//   instret, state_o     retired-instruction count, current state code
//
// Optional feature (macro ILLEGAL_TRAP_EN): an unrecognised instruction halts
// the core and sets the sticky illegal_instr output instead of running as a NOP.

package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
    ALU_AND  = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
    ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      instr,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             zero,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      ir_q,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_wen,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             ext_op,
  output logic             mem_to_reg,
  output logic             lui,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instret,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal_instr,
`endif
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALTED = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e,
                         OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW    = 6'h2b,
                         OP_HALT  = 6'h3f;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_JR   = 6'h08,
                         F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22,
                         F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                         F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2a,
                         F_SLTU = 6'h2b;

  // Wait counter only needs to reach MAX_WAIT; keep at least one bit.
  localparam int           WW   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  state_t             state_q, state_d;
  logic [31:0]        ir_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               retire;
`ifdef ILLEGAL_TRAP_EN
  logic               ill_q, ill_d;
`endif

  // ---------------- instruction decode (from ir_q) ----------------
  logic [5:0] op, fn;
  logic       d_valid, d_j, d_jal, d_jr, d_beq, d_bne, d_lw, d_sw, d_lui, d_halt;
  aluop_t     d_aop;
  logic       d_ext, d_asrc;
  logic [1:0] d_rdst;

  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];

  always_comb begin
    d_valid = 1'b1; d_j = 1'b0; d_jal = 1'b0; d_jr = 1'b0; d_beq = 1'b0;
    d_bne = 1'b0; d_lw = 1'b0; d_sw = 1'b0; d_lui = 1'b0; d_halt = 1'b0;
    d_aop = ALU_SLL; d_ext = 1'b0; d_asrc = 1'b0; d_rdst = 2'd0;
    case (op)
      OP_RTYPE: begin
        d_rdst = 2'd1;
        case (fn)
          F_SLLV:         d_aop = ALU_SLL;
          F_SRLV:         d_aop = ALU_SRL;
          F_JR:           begin d_jr = 1'b1; d_rdst = 2'd0; end
          F_ADD, F_ADDU:  d_aop = ALU_ADD;
          F_SUB, F_SUBU:  d_aop = ALU_SUB;
          F_AND:          d_aop = ALU_AND;
          F_OR:           d_aop = ALU_OR;
          F_XOR:          d_aop = ALU_XOR;
          F_NOR:          d_aop = ALU_NOR;
          F_SLT:          d_aop = ALU_SLT;
          F_SLTU:         d_aop = ALU_SLTU;
          default:        begin d_valid = 1'b0; d_rdst = 2'd0; end
        endcase
      end
      OP_J:              d_j = 1'b1;
      OP_JAL:            begin d_jal = 1'b1; d_rdst = 2'd2; end
      OP_BEQ:            begin d_beq = 1'b1; d_aop = ALU_SUB; d_ext = 1'b1; end
      OP_BNE:            begin d_bne = 1'b1; d_aop = ALU_SUB; d_ext = 1'b1; end
      OP_ADDI, OP_ADDIU: begin d_aop = ALU_ADD;  d_ext = 1'b1; d_asrc = 1'b1; end
      OP_SLTI:           begin d_aop = ALU_SLT;  d_ext = 1'b1; d_asrc = 1'b1; end
      OP_SLTIU:          begin d_aop = ALU_SLTU; d_ext = 1'b1; d_asrc = 1'b1; end
      OP_ANDI:           begin d_aop = ALU_AND; d_asrc = 1'b1; end
      OP_ORI:            begin d_aop = ALU_OR;  d_asrc = 1'b1; end
      OP_XORI:           begin d_aop = ALU_XOR; d_asrc = 1'b1; end
      OP_LUI:            d_lui = 1'b1;
      OP_LW:             begin d_lw = 1'b1; d_aop = ALU_ADD; d_ext = 1'b1; d_asrc = 1'b1; end
      OP_SW:             begin d_sw = 1'b1; d_aop = ALU_ADD; d_ext = 1'b1; d_asrc = 1'b1; end
      OP_HALT:           d_halt = 1'b1;
      default:           d_valid = 1'b0;
    endcase
  end

  // ---------------- state register ----------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_d = state_q; ir_d = ir_q; wcnt_d = '0; tmo_d = tmo_q; retire = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    ill_d = ill_q;
`endif
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; pc_en = 1'b0; pc_src = 2'd0;
    reg_wen = 1'b0; reg_dst = 2'd0; alu_src = 1'b0; alu_op = ALU_SLL;
    ext_op = 1'b0; mem_to_reg = 1'b0; lui = 1'b0; halt = 1'b0;

    // Decode controls stay stable for the whole life of the instruction.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ext_op = d_ext; alu_src = d_asrc; alu_op = d_aop; reg_dst = d_rdst;
      mem_to_reg = d_lw; lui = d_lui;
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_d = instr; pc_en = 1'b1; state_d = S_DECODE;
        end else if (MAX_WAIT != 0 && wcnt_q == WMAX) begin
          tmo_d = 1'b1; state_d = S_HALTED;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_DECODE: begin
        if (d_halt) begin
          state_d = S_HALTED; retire = 1'b1;
        end else if (!d_valid) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALTED; ill_d = 1'b1;
`else
          state_d = S_FETCH; retire = 1'b1;
`endif
        end else if (d_j || d_jal || d_jr) begin
          pc_en = 1'b1; pc_src = d_jr ? 2'd3 : 2'd2; reg_wen = d_jal;
          state_d = S_FETCH; retire = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (d_beq || d_bne) begin
          if ((d_beq && zero) || (d_bne && !zero)) begin
            pc_en = 1'b1; pc_src = 2'd1;
          end
          state_d = S_FETCH; retire = 1'b1;
        end else if (d_lw || d_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dREN = d_lw; dWEN = d_sw;
        if (dhit) begin
          state_d = d_lw ? S_WB : S_FETCH;
          retire  = d_sw;
        end else if (MAX_WAIT != 0 && wcnt_q == WMAX) begin
          tmo_d = 1'b1; state_d = S_HALTED;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_WB: begin
        reg_wen = 1'b1; state_d = S_FETCH; retire = 1'b1;
      end
      S_HALTED: halt = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_timeout = tmo_q;
  assign instret     = cnt_q;
  assign state_o     = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = ill_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised self-checking bench for multicycle_control_unit. A reference
// model turns each instruction (plus its memory wait profile) into an
// expected per-cycle timeline of visible outputs, which is replayed against
// the DUT one cycle at a time. Runs with MAX_WAIT=4 and a 4-bit instret so
// watchdog limits and counter wrap are reachable quickly.
module tb_multicycle_control_unit;
  localparam int MAXW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic CLK = 1'b0, nRST = 1'b0;
  logic [31:0] instr = '0;
  logic ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
  logic iREN, dREN, dWEN, pc_en, reg_wen, alu_src, ext_op, mem_to_reg, lui, halt, mem_timeout;
  logic [31:0] ir_q;
  logic [1:0] pc_src, reg_dst;
  logic [3:0] alu_op, instret;
  logic [2:0] state_o;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_instr;
`endif

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ir_q(ir_q), .pc_en(pc_en), .pc_src(pc_src),
    .reg_wen(reg_wen), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
    .ext_op(ext_op), .mem_to_reg(mem_to_reg), .lui(lui), .halt(halt),
    .mem_timeout(mem_timeout), .instret(instret),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0] st; logic iren, dren, dwen, pc_en; logic [1:0] pc_src;
    logic reg_wen; logic [1:0] reg_dst; logic alu_src; logic [3:0] alu_op;
    logic ext_op, m2r, lui, halt, tmo; logic [31:0] ir; logic [3:0] cnt;
  } obs_t;
  typedef struct packed { logic ihit, dhit, zero, give; } stim_t;
  typedef enum {K_NOP, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_RALU, K_IALU, K_LUI, K_LW, K_SW, K_HALT} kind_e;

  obs_t act;
  assign act = {state_o, iREN, dREN, dWEN, pc_en, pc_src, reg_wen, reg_dst, alu_src, alu_op,
                ext_op, mem_to_reg, lui, halt, mem_timeout, ir_q, instret};

  int ncmp = 0, nerr = 0;
  logic [31:0] ir_m = '0;
  int cnt_m = 0;
  obs_t  exp_q[$];
  stim_t stim_q[$];
  logic [5:0] ops[15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                          6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
  logic [5:0] fns[13] = '{6'h04, 6'h06, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                          6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Instruction table: kind plus the ALU controls the instruction wants.
  // ALU codes: SLL 0 SRL 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 NOR 7 SLT 8 SLTU 9.
  function automatic void classify(input logic [31:0] w, output kind_e k, output logic [3:0] aop,
                                   output logic ext, output logic asrc, output logic [1:0] rdst);
    k = K_NOP; aop = 4'd0; ext = 1'b0; asrc = 1'b0; rdst = 2'd0;
    case (w[31:26])
      6'h00: begin
        k = K_RALU; rdst = 2'd1;
        case (w[5:0])
          6'h04: aop = 4'd0;   6'h06: aop = 4'd1;
          6'h20, 6'h21: aop = 4'd2;  6'h22, 6'h23: aop = 4'd3;
          6'h24: aop = 4'd4;   6'h25: aop = 4'd5;   6'h26: aop = 4'd6;
          6'h27: aop = 4'd7;   6'h2a: aop = 4'd8;   6'h2b: aop = 4'd9;
          6'h08: begin k = K_JR; rdst = 2'd0; end
          default: begin k = K_NOP; rdst = 2'd0; end
        endcase
      end
      6'h02: k = K_J;
      6'h03: begin k = K_JAL; rdst = 2'd2; end
      6'h04: begin k = K_BEQ; aop = 4'd3; ext = 1'b1; end
      6'h05: begin k = K_BNE; aop = 4'd3; ext = 1'b1; end
      6'h08, 6'h09: begin k = K_IALU; aop = 4'd2; ext = 1'b1; asrc = 1'b1; end
      6'h0a: begin k = K_IALU; aop = 4'd8; ext = 1'b1; asrc = 1'b1; end
      6'h0b: begin k = K_IALU; aop = 4'd9; ext = 1'b1; asrc = 1'b1; end
      6'h0c: begin k = K_IALU; aop = 4'd4; asrc = 1'b1; end
      6'h0d: begin k = K_IALU; aop = 4'd5; asrc = 1'b1; end
      6'h0e: begin k = K_IALU; aop = 4'd6; asrc = 1'b1; end
      6'h0f: k = K_LUI;
      6'h23: begin k = K_LW; aop = 4'd2; ext = 1'b1; asrc = 1'b1; end
      6'h2b: begin k = K_SW; aop = 4'd2; ext = 1'b1; asrc = 1'b1; end
      6'h3f: k = K_HALT;
      default: k = K_NOP;
    endcase
  endfunction

  function automatic void push(input obs_t e, input logic ih, input logic dh, input logic z, input logic g);
    exp_q.push_back(e);
    stim_q.push_back({ih, dh, z, g});
  endfunction

  // Expected timeline: iwait fetch misses, then the instruction's phases.
  // zf < 0 means a random zero flag in EXEC.
  function automatic void build(input logic [31:0] iw, input int iwait, input int dwait, input int zf);
    kind_e k; logic [3:0] aop; logic ext, asrc, z; logic [1:0] rdst; obs_t b, d, e;
    classify(iw, k, aop, ext, asrc, rdst);
    b = '0; b.ir = ir_m; b.cnt = 4'(cnt_m % 16);
    for (int i = 0; i <= iwait; i++) begin
      e = b; e.st = S_FETCH; e.iren = 1'b1; e.pc_en = (i == iwait);
      push(e, i == iwait, rb(), rb(), i == iwait);
    end
    d = b; d.ir = iw; d.alu_op = aop; d.ext_op = ext; d.alu_src = asrc; d.reg_dst = rdst;
    d.m2r = (k == K_LW); d.lui = (k == K_LUI);
    e = d; e.st = S_DEC;
    if (k inside {K_J, K_JAL, K_JR}) begin
      e.pc_en = 1'b1; e.pc_src = (k == K_JR) ? 2'd3 : 2'd2; e.reg_wen = (k == K_JAL);
    end
    push(e, rb(), rb(), rb(), 1'b0);
    if (k inside {K_J, K_JAL, K_JR, K_NOP, K_HALT}) return;
    z = (zf < 0) ? rb() : 1'(zf);
    e = d; e.st = S_EXEC;
    if ((k == K_BEQ && z) || (k == K_BNE && !z)) begin e.pc_en = 1'b1; e.pc_src = 2'd1; end
    push(e, rb(), rb(), z, 1'b0);
    if (k inside {K_BEQ, K_BNE}) return;
    if (k inside {K_LW, K_SW}) begin
      for (int i = 0; i <= dwait; i++) begin
        e = d; e.st = S_MEM; e.dren = (k == K_LW); e.dwen = (k == K_SW);
        push(e, rb(), i == dwait, rb(), 1'b0);
      end
    end
    if (k == K_SW) return;
    e = d; e.st = S_WB; e.reg_wen = 1'b1;
    push(e, rb(), rb(), rb(), 1'b0);
  endfunction

  task automatic play(input string tag, input logic [31:0] iw, input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      obs_t e; stim_t s;
      e = exp_q.pop_front(); s = stim_q.pop_front();
      @(negedge CLK);
      ihit = s.ihit; dhit = s.dhit; zero = s.zero; instr = s.give ? iw : $urandom;
      #1; ncmp++;
      if (act !== e) begin
        nerr++; $display("FAIL %s[%0d] instr=%h: got %h want %h", tag, i, iw, act, e);
      end
    end
    exp_q.delete(); stim_q.delete();
  endtask

  task automatic run_instr(input string tag, input logic [31:0] iw, input int iwait, input int dwait, input int zf);
    build(iw, iwait, dwait, zf);
    play(tag, iw, 1000);
    ir_m = iw; cnt_m++;
  endtask

  task automatic check_halted(input string tag, input int n, input logic tmo);
    obs_t e;
    e = '0; e.st = S_HALT; e.halt = 1'b1; e.tmo = tmo; e.ir = ir_m; e.cnt = 4'(cnt_m % 16);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); ihit = rb(); dhit = rb(); zero = rb(); instr = $urandom;
      #1; ncmp++;
      if (act !== e) begin nerr++; $display("FAIL %s[%0d]: got %h want %h", tag, i, act, e); end
    end
  endtask

  // Holds reset for n edges from now, checks the cleared state each cycle,
  // then releases; the DUT is in IDLE for the current cycle and fetches next.
  task automatic do_reset(input string tag, input int n);
    nRST = 1'b0; ir_m = '0; cnt_m = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); ihit = rb(); dhit = rb(); zero = rb(); instr = $urandom;
      #1; ncmp++;
      if (act !== obs_t'(0)) begin nerr++; $display("FAIL %s[%0d]: got %h want 0", tag, i, act); end
    end
    nRST = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w; kind_e k; logic [3:0] a; logic e, s; logic [1:0] r;
    do begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        w[31:26] = ops[$urandom_range(0, 14)];
        if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0) w[5:0] = fns[$urandom_range(0, 12)];
      end
      classify(w, k, a, e, s, r);
`ifdef ILLEGAL_TRAP_EN
    end while (k == K_HALT || k == K_NOP);
`else
    end while (k == K_HALT);
`endif
    return w;
  endfunction

  task automatic test_reset();
    do_reset("reset", 2);
    run_instr("addu", 32'h00221821, 0, 0, -1);
  endtask

  task automatic test_lw();
    run_instr("lw_wait3", 32'h8C220004, 0, 3, -1);
    run_instr("sw", 32'hAC220008, 1, 0, -1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h10220003, 0, 0, 1);
    run_instr("beq_not", 32'h10220003, 0, 0, 0);
    run_instr("bne_taken", 32'h14220003, 0, 0, 0);
    run_instr("bne_not", 32'h14220003, 0, 0, 1);
  endtask

  task automatic test_jumps();
    run_instr("jal", 32'h0C000010, 0, 0, -1);
    run_instr("j", 32'h08000020, 2, 0, -1);
    run_instr("jr", 32'h03E00008, 0, 0, -1);
    run_instr("lui", 32'h3C011234, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_instr("rand", rand_instr(), $urandom_range(0, MAXW), $urandom_range(0, MAXW), -1);
  endtask

  task automatic test_watchdog();
    obs_t e;
    do_reset("wd_rst", 1);
    e = '0; e.st = S_FETCH; e.iren = 1'b1;
    for (int i = 0; i <= MAXW; i++) begin
      @(negedge CLK); ihit = 1'b0; dhit = rb(); zero = rb(); instr = $urandom;
      #1; ncmp++;
      if (act !== e) begin nerr++; $display("FAIL wd_fetch[%0d]: got %h want %h", i, act, e); end
    end
    check_halted("wd_fetch_halt", 11, 1'b1);
    do_reset("wd_rst2", 1);
    run_instr("wd_fetch_edge", 32'h00432025, MAXW, 0, -1);
    run_instr("wd_mem_edge", 32'h8C220004, 0, MAXW, -1);
    build(32'h8C230010, 0, 20, -1);
    play("wd_mem", 32'h8C230010, 3 + MAXW + 1);
    ir_m = 32'h8C230010;
    check_halted("wd_mem_halt", 4, 1'b1);
    do_reset("wd_rst3", 1);
  endtask

  task automatic test_reset_mid();
    run_instr("pre", 32'h24420001, 0, 0, -1);
    build(32'h8C220004, 0, 20, -1);
    play("mid_mem", 32'h8C220004, 5);
    do_reset("mid_rst", 1);
    run_instr("post_rst", 32'h00221821, 0, 0, -1);
  endtask

  task automatic test_halt();
    run_instr("halt", 32'hFC000000, 0, 0, -1);
    check_halted("halted", 6, 1'b0);
    do_reset("halt_rst", 1);
    run_instr("after_halt", 32'h00221821, 1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branch();
    test_jumps();
    test_random();
    test_watchdog();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
